// File: rtl/qmac_pkg.sv
// Shared widths, format selects and types for the quantization MAC datapath.
package qmac_pkg;

   localparam int unsigned WIDTH_OUT     = 16;
   localparam int unsigned WIDTH_EXP     = 5;
   localparam int unsigned WIDTH_MANT    = 10;
   localparam int unsigned WIDTH_INT_MAG = 7;
   localparam int unsigned WIDTH_SAT_CNT = 8;

   localparam logic TYPE_FP16  = 1'b1;
   localparam logic TYPE_FIXED = 1'b0;

   localparam logic [WIDTH_INT_MAG-1:0] MAG_SAT = 7'h7F;

   // Stage-1 payload: raw fields plus the decode needed by the stage-2 packer.
   typedef struct packed {
      logic                  type_sel;
      logic                  sign;
      logic [WIDTH_EXP-1:0]  exp;
      logic [WIDTH_MANT-1:0] mantissa;
      logic [WIDTH_EXP-1:0]  shift;
      logic                  is_zero;
      logic                  is_ovf;
   } s1_t;

endpackage

// File: rtl/output_int_round.sv
// Fixed-point magnitude: denormalizing shift, round/sticky, RNE and rounding saturation.
// OUTPUT_LAST_ROUND_EN selects round-to-nearest-even; otherwise the magnitude is truncated.
module output_int_round
   import qmac_pkg::*;
(
   input  logic [WIDTH_MANT-1:0]    mantissa,
   input  logic [WIDTH_EXP-1:0]     shift,
   output logic [WIDTH_INT_MAG-1:0] mag,
   output logic                     sat
);

   localparam int unsigned EXT_W = WIDTH_MANT + WIDTH_INT_MAG + 1;

   logic [EXT_W-1:0]         ext;
   logic [WIDTH_INT_MAG-1:0] pre;
   logic                     far;

   // Leading one plus mantissa, padded so every bit shifted out stays visible for sticky.
   assign ext = {1'b1, mantissa, {WIDTH_INT_MAG{1'b0}}} >> shift[2:0];
   assign pre = ext[EXT_W-1 -: WIDTH_INT_MAG];
   // Shifts of 8 or more always produce zero, rounding included.
   assign far = |shift[WIDTH_EXP-1:3];

`ifdef OUTPUT_LAST_ROUND_EN
   logic                   round_bit;
   logic                   sticky;
   logic                   inc;
   logic [WIDTH_INT_MAG:0] sum;

   assign round_bit = ext[EXT_W-1-WIDTH_INT_MAG];
   assign sticky    = |ext[EXT_W-2-WIDTH_INT_MAG:0];
   assign inc       = round_bit & (sticky | pre[0]);
   assign sum       = {1'b0, pre} + {{WIDTH_INT_MAG{1'b0}}, inc};

   always_comb begin
      mag = sum[WIDTH_INT_MAG-1:0];
      sat = 1'b0;
      if (far) begin
         mag = '0;
      end else if (sum[WIDTH_INT_MAG]) begin
         mag = MAG_SAT;
         sat = 1'b1;
      end
   end
`else
   logic unused_low;

   assign unused_low = ^ext[EXT_W-1-WIDTH_INT_MAG:0];
   assign mag        = far ? '0 : pre;
   assign sat        = 1'b0;
`endif

endmodule

// File: rtl/output_last.sv
// Two-stage output packer: FP16 repack or sign-magnitude fixed point with saturation count.
// OUTPUT_LAST_ROUND_EN enables round-to-nearest-even in the fixed-point path.
module output_last
   import qmac_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     in_sign,
   input  logic [WIDTH_EXP-1:0]     in_exp,
   input  logic [WIDTH_MANT-1:0]    in_mantissa,
   input  logic                     in_zero_flag,
   input  logic                     type_sel,
   input  logic [WIDTH_EXP-1:0]     n,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH_OUT-1:0]     outdata,
   output logic                     sat_flag,
   output logic [WIDTH_SAT_CNT-1:0] sat_cnt,
   input  logic                     sat_clr
);

   localparam int unsigned PAD_W = WIDTH_OUT - WIDTH_INT_MAG - 1;

   s1_t                      s1_q, s1_d;
   logic                     s1_valid_q, s2_valid_q;
   logic [WIDTH_OUT-1:0]     out_q, out_d;
   logic                     sat_q, sat_d;
   logic [WIDTH_SAT_CNT-1:0] cnt_q;
   logic                     s1_adv, s2_adv;
   logic [WIDTH_INT_MAG-1:0] rnd_mag;
   logic                     rnd_sat;

   assign s2_adv   = en & (~s2_valid_q | out_ready);
   assign s1_adv   = en & (~s1_valid_q | s2_adv);
   assign in_ready = rst & s1_adv;

   assign out_valid = s2_valid_q;
   assign outdata   = out_q;
   assign sat_flag  = sat_q;
   assign sat_cnt   = cnt_q;

   always_comb begin
      s1_d          = '0;
      s1_d.type_sel = type_sel;
      s1_d.sign     = in_sign;
      s1_d.exp      = in_exp;
      s1_d.mantissa = in_mantissa;
      s1_d.shift    = n - in_exp;
      s1_d.is_zero  = in_zero_flag | (in_exp == '0);
      s1_d.is_ovf   = in_exp > n;
   end

   output_int_round u_round (
      .mantissa (s1_q.mantissa),
      .shift    (s1_q.shift),
      .mag      (rnd_mag),
      .sat      (rnd_sat)
   );

   always_comb begin
      out_d = '0;
      sat_d = 1'b0;
      if (s1_q.type_sel == TYPE_FP16) begin
         out_d = {s1_q.sign, s1_q.exp, s1_q.mantissa};
      end else if (s1_q.is_zero) begin
         out_d = '0;
      end else if (s1_q.is_ovf) begin
         out_d = {s1_q.sign, {PAD_W{1'b0}}, MAG_SAT};
         sat_d = 1'b1;
      end else begin
         // A magnitude that ends up zero never carries a negative sign.
         out_d = {s1_q.sign & (|rnd_mag), {PAD_W{1'b0}}, rnd_mag};
         sat_d = rnd_sat;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_q       <= '0;
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         out_q      <= '0;
         sat_q      <= 1'b0;
         cnt_q      <= '0;
      end else begin
         if (s1_adv) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
               s1_q <= s1_d;
            end
         end
         if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
               out_q <= out_d;
               sat_q <= sat_d;
            end
         end
         if (sat_clr) begin
            cnt_q <= '0;
         end else if (en & s2_valid_q & out_ready & sat_q & ~&cnt_q) begin
            cnt_q <= cnt_q + WIDTH_SAT_CNT'(1);
         end
      end
   end

endmodule
